native_axil_master: RTL

- AXI4-Lite initiator that converts the CPU native memory interface (valid/ready, addr, wdata, wstrb, rdata) into single AXI4-Lite read or write transactions.
- Acts as the opposite end of the AXI-Lite UART responder: the CPU drives requests through this block onto the SoC AXI-Lite fabric.
- Supports one outstanding transaction at a time, in order.
- AXI error responses are reported back to the CPU as a one-cycle error pulse.

---
 rtl/soc_axi_pkg.sv | 26 ++
 rtl/native_axil_master.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/soc_axi_pkg.sv
// Shared AXI4-Lite definitions: master FSM states, response and protection encodings.
package soc_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } axil_mst_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_INSN = 3'b100;

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/native_axil_master.sv
// Native CPU memory interface to AXI4-Lite initiator, one transaction in flight.
module native_axil_master
  import soc_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);

  axil_mst_state_t state;
  logic            aw_done;
  logic            w_done;
  logic            aw_hs;
  logic            w_hs;

  // Channel handshakes seen this cycle on the write address and write data channels.
  always_comb begin
    aw_hs = m_awvalid & m_awready;
    w_hs  = m_wvalid & m_wready;
  end

  // Transaction sequencer; the request is latched straight into the AXI payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awprot  <= '0;
      m_wvalid  <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= '0;
      m_rready  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (mem_wstrb != 4'b0000) begin
              m_awaddr  <= mem_addr;
              m_awprot  <= PROT_DATA;
              m_wdata   <= mem_wdata;
              m_wstrb   <= mem_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR_REQ;
            end else begin
              m_araddr  <= mem_addr;
              m_arprot  <= mem_instr ? PROT_INSN : PROT_DATA;
              m_arvalid <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid && m_bready) begin
            m_bready  <= 1'b0;
            mem_ready <= 1'b1;
            mem_err   <= resp_is_err(m_bresp);
            state     <= DONE;
          end
        end
        RD_REQ: begin
          if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_rvalid && m_rready) begin
            m_rready  <= 1'b0;
            mem_rdata <= m_rdata;
            mem_ready <= 1'b1;
            mem_err   <= resp_is_err(m_rresp);
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
